// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// default bit period (100 MHz / 115200) used by both transmit and receive sides.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to
// RESET_VAL so the synchronized value is well defined out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, 8N1 deframing (8E1 with UART_RX_PARITY_EN),
// one-entry valid/ready output buffer with framing/overrun/parity error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       line_in,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic       framing_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int unsigned       CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rx;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (line_in),
    .q     (rx)
  );

  rx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [7:0]                rd_data_q, rd_data_d;
  logic                      framing_err_q, framing_err_d;
  logic                      overrun_q, overrun_d;
  logic                      complete;
  logic                      load;
`ifdef UART_RX_PARITY_EN
  logic                      parity_bad_q, parity_bad_d;
  logic                      parity_err_q, parity_err_d;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= parity_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    framing_err_d = 1'b0;
    complete      = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d  = parity_bad_q;
    parity_err_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx, shreg_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          parity_bad_d = rx ^ (^shreg_q);
          state_d      = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop gives half a bit of slack to catch the next start edge.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            parity_bad_d = 1'b0;
            if (parity_bad_q) parity_err_d = 1'b1;
            else              complete     = 1'b1;
`else
            complete = 1'b1;
`endif
          end else begin
            framing_err_d = 1'b1;
            state_d       = BREAK;
`ifdef UART_RX_PARITY_EN
            parity_bad_d  = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A drain in the same cycle frees the buffer for the completing byte.
    load       = complete && (!rd_valid_q || rd_ready);
    overrun_d  = complete && rd_valid_q && !rd_ready;
    rd_data_d  = load ? shreg_q : rd_data_q;
    rd_valid_d = load || (rd_valid_q && !rd_ready);
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule
